// File: rtl/spi_slave_duplex.sv
// Full-duplex SPI slave on i_clk: oversampled pads, RX word out, TX word from a one-deep holding buffer.
// Latency: ~3-4 i_clk from an SCLK sample edge to o_rx_valid; MISO changes ~4 i_clk after a shift edge.
// Backpressure: none on RX (o_rx_data is overwritten by the next word); TX write is taken only while o_tx_ready=1.
// Ports: i_clk/i_rst_n system clock and async active-low reset; i_cs/i_s_clk/i_mosi raw SPI pads;
//        o_miso/o_miso_oe MISO pad data and enable; i_tx_data/i_tx_valid/o_tx_ready TX buffer write;
//        o_rx_data/o_rx_valid received word; o_tx_underrun word load found no data; o_busy frame active.
module spi_slave_duplex #(
   parameter int DATA_W    = 8,
   parameter bit CPOL      = 1'b0,
   parameter bit CPHA      = 1'b0,
   parameter bit LSB_FIRST = 1'b0
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_cs,
   input  logic              i_s_clk,
   input  logic              i_mosi,
   output logic              o_miso,
   output logic              o_miso_oe,
   input  logic [DATA_W-1:0] i_tx_data,
   input  logic              i_tx_valid,
   output logic              o_tx_ready,
   output logic [DATA_W-1:0] o_rx_data,
   output logic              o_rx_valid,
   output logic              o_tx_underrun,
   output logic              o_busy
);

   localparam int CW = $clog2(DATA_W);
   localparam logic [CW-1:0] CNT_LAST = CW'(DATA_W - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   typedef enum logic [0:0] {ST_IDLE, ST_ACTIVE} state_t;

   // pad synchronisers
   logic [1:0]        cs_s_q, mosi_s_q;
   logic [2:0]        sclk_s_q;

   state_t            state_q,     state_d;
   logic [DATA_W-1:0] rx_shift_q,  rx_shift_d;
   logic [CW-1:0]     rx_cnt_q,    rx_cnt_d;
   logic [DATA_W-1:0] tx_shift_q,  tx_shift_d;
   logic [CW-1:0]     tx_cnt_q,    tx_cnt_d;
   logic [DATA_W-1:0] tx_buf_q,    tx_buf_d;
   logic              tx_full_q,   tx_full_d;
   logic [DATA_W-1:0] rx_data_q,   rx_data_d;
   logic              rx_valid_q,  rx_valid_d;
   logic              underrun_q,  underrun_d;
   logic              oe_q,        oe_d;
   logic              busy_q,      busy_d;

   logic              cs_sync, mosi_sync;
   logic              sclk_rise, sclk_fall, lead_edge, trail_edge, sample_edge, shift_edge;
   logic              tx_write, tx_load;
   logic [DATA_W-1:0] rx_shift_nxt, tx_shift_nxt, tx_load_word;

   assign cs_sync   = cs_s_q[1];
   assign mosi_sync = mosi_s_q[1];

   // edges come from the two oldest SCLK stages so the first stage can settle
   assign sclk_rise   = sclk_s_q[1] & ~sclk_s_q[2];
   assign sclk_fall   = ~sclk_s_q[1] & sclk_s_q[2];
   assign lead_edge   = CPOL ? sclk_fall : sclk_rise;
   assign trail_edge  = CPOL ? sclk_rise : sclk_fall;
   assign sample_edge = CPHA ? trail_edge : lead_edge;
   assign shift_edge  = CPHA ? lead_edge  : trail_edge;

   assign rx_shift_nxt = LSB_FIRST ? {mosi_sync, rx_shift_q[DATA_W-1:1]}
                                   : {rx_shift_q[DATA_W-2:0], mosi_sync};
   assign tx_shift_nxt = LSB_FIRST ? {1'b0, tx_shift_q[DATA_W-1:1]}
                                   : {tx_shift_q[DATA_W-2:0], 1'b0};
   assign tx_load_word = tx_full_q ? tx_buf_q : '0;
   assign tx_write     = i_tx_valid && !tx_full_q;

   always_comb begin
      state_d    = state_q;
      rx_shift_d = rx_shift_q;
      rx_cnt_d   = rx_cnt_q;
      tx_shift_d = tx_shift_q;
      tx_cnt_d   = tx_cnt_q;
      rx_data_d  = rx_data_q;
      oe_d       = oe_q;
      busy_d     = busy_q;
      rx_valid_d = 1'b0;
      underrun_d = 1'b0;
      tx_load    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!cs_sync) begin
               state_d = ST_ACTIVE;
               oe_d    = 1'b1;
               busy_d  = 1'b1;
               // CPHA=0 must present bit 0 before the first leading edge
               tx_load = !CPHA;
            end
         end
         ST_ACTIVE: begin
            if (cs_sync) begin
               // frame end: drop any partial word, keep the TX buffer
               state_d    = ST_IDLE;
               oe_d       = 1'b0;
               busy_d     = 1'b0;
               rx_cnt_d   = '0;
               tx_cnt_d   = '0;
               rx_shift_d = '0;
               tx_shift_d = '0;
            end else begin
               if (sample_edge) begin
                  rx_shift_d = rx_shift_nxt;
                  if (rx_cnt_q == CNT_LAST) begin
                     rx_cnt_d   = '0;
                     rx_data_d  = rx_shift_nxt;
                     rx_valid_d = 1'b1;
                  end else begin
                     rx_cnt_d = rx_cnt_q + CNT_ONE;
                  end
               end
               if (shift_edge) begin
                  // CPHA=0 reloads on the last shift of a word, CPHA=1 on the first
                  if (CPHA ? (tx_cnt_q == '0) : (tx_cnt_q == CNT_LAST))
                     tx_load = 1'b1;
                  else
                     tx_shift_d = tx_shift_nxt;
                  tx_cnt_d = (tx_cnt_q == CNT_LAST) ? '0 : tx_cnt_q + CNT_ONE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (tx_load) begin
         tx_shift_d = tx_load_word;
         underrun_d = !tx_full_q;
      end
      // a write racing a load into an empty buffer survives for the next word
      tx_full_d = tx_write | (tx_full_q & ~tx_load);
      tx_buf_d  = tx_write ? i_tx_data : tx_buf_q;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cs_s_q     <= 2'b11;
         mosi_s_q   <= 2'b00;
         sclk_s_q   <= {3{CPOL}};
         state_q    <= ST_IDLE;
         rx_shift_q <= '0;
         rx_cnt_q   <= '0;
         tx_shift_q <= '0;
         tx_cnt_q   <= '0;
         tx_buf_q   <= '0;
         tx_full_q  <= 1'b0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         underrun_q <= 1'b0;
         oe_q       <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         cs_s_q     <= {cs_s_q[0], i_cs};
         mosi_s_q   <= {mosi_s_q[0], i_mosi};
         sclk_s_q   <= {sclk_s_q[1:0], i_s_clk};
         state_q    <= state_d;
         rx_shift_q <= rx_shift_d;
         rx_cnt_q   <= rx_cnt_d;
         tx_shift_q <= tx_shift_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_buf_q   <= tx_buf_d;
         tx_full_q  <= tx_full_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         underrun_q <= underrun_d;
         oe_q       <= oe_d;
         busy_q     <= busy_d;
      end
   end

   assign o_miso        = LSB_FIRST ? tx_shift_q[0] : tx_shift_q[DATA_W-1];
   assign o_miso_oe     = oe_q;
   assign o_tx_ready    = !tx_full_q;
   assign o_rx_data     = rx_data_q;
   assign o_rx_valid    = rx_valid_q;
   assign o_tx_underrun = underrun_q;
   assign o_busy        = busy_q;

endmodule

// File: tb/tb_spi_slave_duplex.sv
// Directed bench for spi_slave_duplex: five instances cover modes 0-3 and LSB-first mode 0.
// Index 0 mode0 MSB, 1 mode1, 2 mode2, 3 mode3, 4 mode0 LSB-first.
`timescale 1ns/1ps
module tb_spi_slave_duplex;
   localparam int H  = 80;   // SCLK half period = 8 i_clk periods
   localparam int ND = 5;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       mosi;
   logic       cs[ND], sck[ND], txv[ND];
   logic [7:0] txd[ND];
   logic       miso[ND], oe[ND], txr[ND], rxv[ND], und[ND], busy[ND];
   logic [7:0] rxd[ND];

   logic [7:0] txw[ND][16];
   int         txn[ND], txi[ND];
   logic [7:0] rxlog[ND][16];
   int         rxn[ND], unn[ND];
   int         checks = 0, passed = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < ND; g++) begin : g_dut
      spi_slave_duplex #(
         .DATA_W(8), .CPOL(g == 2 || g == 3), .CPHA(g == 1 || g == 3), .LSB_FIRST(g == 4)
      ) u_dut (
         .i_clk(clk), .i_rst_n(rst_n), .i_cs(cs[g]), .i_s_clk(sck[g]), .i_mosi(mosi),
         .o_miso(miso[g]), .o_miso_oe(oe[g]), .i_tx_data(txd[g]), .i_tx_valid(txv[g]),
         .o_tx_ready(txr[g]), .o_rx_data(rxd[g]), .o_rx_valid(rxv[g]),
         .o_tx_underrun(und[g]), .o_busy(busy[g])
      );
   end

   function automatic bit cpol(input int d); return (d == 2 || d == 3); endfunction
   function automatic bit cpha(input int d); return (d == 1 || d == 3); endfunction
   function automatic bit lsb(input int d);  return (d == 4);           endfunction

   // TX feeder: presents queued words, advances when a write was accepted on the posedge
   initial begin
      bit acc[ND];
      for (int d = 0; d < ND; d++) begin txi[d] = 0; txv[d] = 1'b0; txd[d] = 8'h00; end
      forever begin
         @(posedge clk);
         for (int d = 0; d < ND; d++) acc[d] = txv[d] && txr[d] && rst_n;
         @(negedge clk);
         for (int d = 0; d < ND; d++) begin
            if (acc[d]) txi[d]++;
            txv[d] = (txi[d] < txn[d]);
            txd[d] = txv[d] ? txw[d][txi[d] % 16] : 8'h00;
         end
      end
   end

   // RX / underrun monitor
   initial begin
      for (int d = 0; d < ND; d++) begin rxn[d] = 0; unn[d] = 0; end
      forever begin
         @(negedge clk);
         for (int d = 0; d < ND; d++) begin
            if (rxv[d] === 1'b1) begin rxlog[d][rxn[d] % 16] = rxd[d]; rxn[d]++; end
            if (und[d] === 1'b1) unn[d]++;
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic push(input int d, input logic [7:0] v);
      txw[d][txn[d] % 16] = v;
      txn[d]++;
   endtask

   task automatic wait_ready(input int d, input logic v);
      int n = 0;
      while (txr[d] !== v && n < 50) begin @(negedge clk); n++; end
      checks++;
      if (txr[d] !== v) $display("FAIL wait_ready[%0d]: o_tx_ready=%b required %b within 50 cycles", d, txr[d], v);
      else passed++;
   endtask

   // SPI master: word w occupies mo/mi[8w+7:8w]; unstable counts MISO changes outside the shift edge
   task automatic frame(input int d, input int nbits, input logic [23:0] mo,
                        output logic [23:0] mi, output int unstable);
      int idx;
      logic v;
      mi = '0;
      unstable = 0;
      cs[d] = 1'b0;
      #H;
      for (int b = 0; b < nbits; b++) begin
         idx = (b / 8) * 8 + (lsb(d) ? (b % 8) : 7 - (b % 8));
         if (!cpha(d)) begin
            mosi = mo[idx];
            #H;
            v = miso[d]; mi[idx] = v;
            sck[d] = ~cpol(d);
            #(H - 10);
            if (miso[d] !== v) unstable++;
            #10;
            sck[d] = cpol(d);
         end else begin
            sck[d] = ~cpol(d);
            mosi = mo[idx];
            #H;
            v = miso[d]; mi[idx] = v;
            sck[d] = cpol(d);
            #(H - 10);
            if (miso[d] !== v) unstable++;
            #10;
         end
      end
      #H;
      cs[d] = 1'b1;
      #(4 * H);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks += 7;
      if (miso[0] !== 1'b0)    $display("FAIL reset_miso: got %b required 0", miso[0]);    else passed++;
      if (oe[0] !== 1'b0)      $display("FAIL reset_oe: got %b required 0", oe[0]);        else passed++;
      if (rxd[0] !== 8'h00)    $display("FAIL reset_rx_data: got %h required 00", rxd[0]); else passed++;
      if (rxv[0] !== 1'b0)     $display("FAIL reset_rx_valid: got %b required 0", rxv[0]); else passed++;
      if (und[0] !== 1'b0)     $display("FAIL reset_underrun: got %b required 0", und[0]); else passed++;
      if (busy[0] !== 1'b0)    $display("FAIL reset_busy: got %b required 0", busy[0]);    else passed++;
      if (txr[0] !== 1'b1)     $display("FAIL reset_tx_ready: got %b required 1", txr[0]); else passed++;
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_mode0();
      logic [23:0] mi;
      int un, rb, ub;
      push(0, 8'hA5);
      push(0, 8'h96);   // refill so the end-of-word reload is not an underrun
      wait_ready(0, 1'b0);
      rb = rxn[0]; ub = unn[0];
      @(negedge clk);
      fork
         frame(0, 8, 24'h00003C, mi, un);
         begin
            #(3 * H);
            checks += 2;
            if (oe[0] !== 1'b1)   $display("FAIL m0_oe_active: got %b required 1", oe[0]);     else passed++;
            if (busy[0] !== 1'b1) $display("FAIL m0_busy_active: got %b required 1", busy[0]); else passed++;
         end
      join
      checks += 8;
      if (rxn[0] - rb != 1)     $display("FAIL m0_rx_pulses: got %0d required 1", rxn[0] - rb); else passed++;
      if (rxd[0] !== 8'h3C)     $display("FAIL m0_rx_data: got %h required 3c", rxd[0]);        else passed++;
      if (mi[7:0] !== 8'hA5)    $display("FAIL m0_miso_word: got %h required a5", mi[7:0]);     else passed++;
      if (unn[0] - ub != 0)     $display("FAIL m0_underrun: got %0d required 0", unn[0] - ub);  else passed++;
      if (un != 0)              $display("FAIL m0_miso_stable: got %0d changes required 0", un); else passed++;
      if (busy[0] !== 1'b0)     $display("FAIL m0_busy_idle: got %b required 0", busy[0]);      else passed++;
      if (oe[0] !== 1'b0)       $display("FAIL m0_oe_idle: got %b required 0", oe[0]);          else passed++;
      if (txr[0] !== 1'b1)      $display("FAIL m0_tx_ready: got %b required 1", txr[0]);        else passed++;
   endtask

   task automatic test_modes();
      logic [23:0] mi;
      int un, rb;
      for (int d = 1; d < ND; d++) begin
         push(d, 8'hA5);
         wait_ready(d, 1'b0);
         rb = rxn[d];
         @(negedge clk);
         frame(d, 8, 24'h00003C, mi, un);
         checks += 4;
         if (rxd[d] !== 8'h3C)  $display("FAIL mode%0d_rx_data: got %h required 3c", d, rxd[d]);        else passed++;
         if (rxn[d] - rb != 1)  $display("FAIL mode%0d_rx_pulses: got %0d required 1", d, rxn[d] - rb); else passed++;
         if (mi[7:0] !== 8'hA5) $display("FAIL mode%0d_miso_word: got %h required a5", d, mi[7:0]);     else passed++;
         if (un != 0)           $display("FAIL mode%0d_miso_stable: got %0d changes required 0", d, un); else passed++;
      end
   endtask

   task automatic test_back_to_back();
      logic [23:0] mi;
      int un, rb, ub;
      push(0, 8'hA1); push(0, 8'hB2); push(0, 8'hC3); push(0, 8'hD4);
      wait_ready(0, 1'b0);
      rb = rxn[0]; ub = unn[0];
      @(negedge clk);
      frame(0, 24, 24'h332211, mi, un);
      checks += 6;
      if (rxn[0] - rb != 3)           $display("FAIL b2b_rx_pulses: got %0d required 3", rxn[0] - rb);        else passed++;
      if (rxlog[0][rb % 16] !== 8'h11)       $display("FAIL b2b_rx0: got %h required 11", rxlog[0][rb % 16]);       else passed++;
      if (rxlog[0][(rb + 1) % 16] !== 8'h22) $display("FAIL b2b_rx1: got %h required 22", rxlog[0][(rb + 1) % 16]); else passed++;
      if (rxlog[0][(rb + 2) % 16] !== 8'h33) $display("FAIL b2b_rx2: got %h required 33", rxlog[0][(rb + 2) % 16]); else passed++;
      if (mi !== 24'hC3B2A1)          $display("FAIL b2b_miso_words: got %h required c3b2a1", mi);            else passed++;
      if (unn[0] - ub != 0)           $display("FAIL b2b_underrun: got %0d required 0", unn[0] - ub);         else passed++;
   endtask

   task automatic test_underrun();
      logic [23:0] mi;
      int un, ub;
      checks++;
      if (txr[1] !== 1'b1) $display("FAIL ur_buffer_empty: got %b required 1", txr[1]); else passed++;
      ub = unn[1];
      @(negedge clk);
      frame(1, 8, 24'h00005A, mi, un);
      checks += 3;
      if (mi[7:0] !== 8'h00) $display("FAIL ur_miso_word: got %h required 00", mi[7:0]);    else passed++;
      if (unn[1] - ub != 1)  $display("FAIL ur_pulses: got %0d required 1", unn[1] - ub);   else passed++;
      if (rxd[1] !== 8'h5A)  $display("FAIL ur_rx_data: got %h required 5a", rxd[1]);      else passed++;
   endtask

   task automatic test_abort();
      logic [23:0] mi;
      int un, rb;
      rb = rxn[0];
      @(negedge clk);
      fork
         frame(0, 5, 24'h00001F, mi, un);
         begin #(3 * H); push(0, 8'h7E); end
      join
      checks += 3;
      if (rxn[0] - rb != 0) $display("FAIL abort_no_valid: got %0d pulses required 0", rxn[0] - rb); else passed++;
      if (txr[0] !== 1'b0)  $display("FAIL abort_buffer_kept: tx_ready %b required 0", txr[0]);     else passed++;
      if (busy[0] !== 1'b0) $display("FAIL abort_busy: got %b required 0", busy[0]);                else passed++;
      rb = rxn[0];
      @(negedge clk);
      frame(0, 8, 24'h0000C3, mi, un);
      checks += 3;
      if (rxn[0] - rb != 1)  $display("FAIL abort_next_pulses: got %0d required 1", rxn[0] - rb); else passed++;
      if (rxd[0] !== 8'hC3)  $display("FAIL abort_next_rx: got %h required c3", rxd[0]);          else passed++;
      if (mi[7:0] !== 8'h7E) $display("FAIL abort_next_miso: got %h required 7e", mi[7:0]);      else passed++;
   endtask

   task automatic test_reset_mid();
      logic [23:0] mi;
      int un;
      push(0, 8'h55); push(0, 8'h66);
      wait_ready(0, 1'b0);
      @(negedge clk);
      fork
         frame(0, 8, 24'h0000F0, mi, un);
         begin
            #(5 * H);
            checks += 2;
            if (txr[0] !== 1'b0) $display("FAIL rm_pre_ready: got %b required 0", txr[0]); else passed++;
            if (oe[0] !== 1'b1)  $display("FAIL rm_pre_oe: got %b required 1", oe[0]);     else passed++;
            rst_n = 1'b0;
            #1;
            checks += 7;
            if (miso[0] !== 1'b0) $display("FAIL rm_miso: got %b required 0", miso[0]);     else passed++;
            if (oe[0] !== 1'b0)   $display("FAIL rm_oe: got %b required 0", oe[0]);         else passed++;
            if (busy[0] !== 1'b0) $display("FAIL rm_busy: got %b required 0", busy[0]);     else passed++;
            if (rxd[0] !== 8'h00) $display("FAIL rm_rx_data: got %h required 00", rxd[0]);  else passed++;
            if (rxv[0] !== 1'b0)  $display("FAIL rm_rx_valid: got %b required 0", rxv[0]);  else passed++;
            if (und[0] !== 1'b0)  $display("FAIL rm_underrun: got %b required 0", und[0]);  else passed++;
            if (txr[0] !== 1'b1)  $display("FAIL rm_tx_ready: got %b required 1", txr[0]);  else passed++;
         end
      join
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      checks += 2;
      if (txr[0] !== 1'b1)  $display("FAIL rm_post_ready: got %b required 1", txr[0]); else passed++;
      if (busy[0] !== 1'b0) $display("FAIL rm_post_busy: got %b required 0", busy[0]); else passed++;
   endtask

   initial begin
      mosi = 1'b0;
      for (int d = 0; d < ND; d++) begin cs[d] = 1'b1; sck[d] = cpol(d); txn[d] = 0; end
      test_reset();
      test_mode0();
      test_modes();
      test_back_to_back();
      test_underrun();
      test_abort();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
